// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, FSM states, ALU ops.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

  function automatic alu_op_t funct_to_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  // 32-bit wrap arithmetic; slt compares as signed
  function automatic logic [31:0] alu_exec(input alu_op_t op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 fixed at 0.
module mc_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] regs_reg [32];
  logic [31:0] wr_sel;

  // One write-enable per register; entry 0 never gets one so writes to $0 vanish
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_wr_sel
      if (gi == 0) begin : g_zero
        assign wr_sel[gi] = 1'b0;
      end else begin : g_reg
        assign wr_sel[gi] = we && (waddr == 5'(gi));
      end
    end
  endgenerate

  // Register storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) if (wr_sel[i]) regs_reg[i] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_reg[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_reg[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core with a single req/ack memory port.
// The next fetch request is launched on the retire edge, so a fetch acked in
// its first request cycle costs exactly one cycle.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          CNT_WIDTH   = 32,
  parameter bit          ENABLE_JUMP = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata,
  output logic                 halted,
  output logic                 illegal_instr,
  output logic                 misaligned,
  output logic [CNT_WIDTH-1:0] retired_cnt
);
  import mips_pkg::*;

  state_t state_reg, state_next;
  logic [31:0] pc_reg, pc_next, ir_reg, ir_next, a_reg, a_next, b_reg, b_next;
  logic [31:0] alu_out_reg, alu_out_next, mdr_reg, mdr_next;
  logic [31:0] mem_addr_reg, mem_addr_next, mem_wdata_reg, mem_wdata_next;
  logic        mem_req_reg, mem_req_next, mem_we_reg, mem_we_next;
  logic        halted_reg, halted_next, illegal_reg, illegal_next;
  logic        misaligned_reg, misaligned_next, retire;
  logic [CNT_WIDTH-1:0] retired_reg, retired_next;

  logic [5:0]  opcode, funct;
  logic [31:0] imm_sext, beq_target, j_target, rs_data, rt_data, rf_wdata, alu_result;
  logic [4:0]  rf_waddr;
  logic        rf_we, is_rtype, is_mem_op, op_legal;

  assign opcode     = ir_reg[31:26];
  assign funct      = ir_reg[5:0];
  assign imm_sext   = sext16(ir_reg[15:0]);
  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_mem_op  = (opcode == OP_LW) || (opcode == OP_SW);
  // pc_reg already holds pc+4 once the instruction is latched
  assign beq_target = pc_reg + {imm_sext[29:0], 2'b00};
  assign j_target   = {pc_reg[31:28], ir_reg[25:0], 2'b00};
  assign alu_result = alu_exec(is_rtype ? funct_to_alu_op(funct) : ALU_ADD,
                               a_reg, is_rtype ? b_reg : imm_sext);
  assign rf_waddr   = is_rtype ? ir_reg[15:11] : ir_reg[20:16];
  assign rf_wdata   = (opcode == OP_LW) ? mdr_reg : alu_out_reg;

  mc_regfile u_regfile (
    .clk(clk), .rst_n(rst_n), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr_a(ir_reg[25:21]), .raddr_b(ir_reg[20:16]),
    .rdata_a(rs_data), .rdata_b(rt_data)
  );

  // Opcode/funct legality check used in DECODE
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE:                             op_legal = funct_legal(funct);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: op_legal = 1'b1;
      OP_J:                                 op_legal = ENABLE_JUMP;
      default:                              op_legal = 1'b0;
    endcase
  end

  // FSM next-state and datapath register updates
  always_comb begin
    state_next = state_reg;        pc_next = pc_reg;          ir_next = ir_reg;
    a_next = a_reg;                b_next = b_reg;            alu_out_next = alu_out_reg;
    mdr_next = mdr_reg;            mem_req_next = mem_req_reg; mem_we_next = mem_we_reg;
    mem_addr_next = mem_addr_reg;  mem_wdata_next = mem_wdata_reg;
    halted_next = halted_reg;      illegal_next = illegal_reg; misaligned_next = misaligned_reg;
    retire = 1'b0;                 rf_we = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (mem_req_reg) begin
          if (mem_ack) begin
            ir_next = mem_rdata;  pc_next = pc_reg + 32'd4;
            mem_req_next = 1'b0;  state_next = S_DECODE;
          end
        end else begin
          // only reached straight out of reset: launch the first fetch
          mem_req_next = 1'b1;  mem_we_next = 1'b0;  mem_addr_next = pc_reg;
        end
      end
      S_DECODE: begin
        a_next = rs_data;  b_next = rt_data;
        if (!op_legal) begin
          illegal_next = 1'b1;  halted_next = 1'b1;  state_next = S_HALT;
        end else if (opcode == OP_BEQ || opcode == OP_J) begin
          if (opcode == OP_J)             pc_next = j_target;
          else if (rs_data == rt_data)    pc_next = beq_target;
          mem_req_next  = 1'b1;  mem_we_next = 1'b0;
          mem_addr_next = (opcode == OP_J) ? j_target :
                          (rs_data == rt_data) ? beq_target : pc_reg;
          retire = 1'b1;  state_next = S_FETCH;
        end else if (opcode == OP_HALT) begin
          halted_next = 1'b1;  retire = 1'b1;  state_next = S_HALT;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_out_next = alu_result;
        if (is_mem_op) begin
          state_next = S_MEM;
          // a misaligned address never reaches the bus; MEM turns it into a halt
          if (alu_result[1:0] == 2'b00) begin
            mem_req_next  = 1'b1;  mem_we_next = (opcode == OP_SW);
            mem_addr_next = alu_result;
            if (opcode == OP_SW) mem_wdata_next = b_reg;
          end
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (alu_out_reg[1:0] != 2'b00) begin
          misaligned_next = 1'b1;  halted_next = 1'b1;  state_next = S_HALT;
        end else if (mem_req_reg && mem_ack) begin
          mem_req_next = 1'b0;  mem_we_next = 1'b0;
          if (opcode == OP_LW) begin
            mdr_next = mem_rdata;  state_next = S_WB;
          end else begin
            mem_req_next = 1'b1;  mem_addr_next = pc_reg;
            retire = 1'b1;        state_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we = 1'b1;  retire = 1'b1;  state_next = S_FETCH;
        mem_req_next = 1'b1;  mem_we_next = 1'b0;  mem_addr_next = pc_reg;
      end
      default: begin
        state_next = S_HALT;
      end
    endcase
    retired_next = retire ? retired_reg + CNT_WIDTH'(1) : retired_reg;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;  pc_reg <= RESET_PC;  ir_reg <= '0;
      a_reg <= '0;  b_reg <= '0;  alu_out_reg <= '0;  mdr_reg <= '0;
      mem_req_reg <= 1'b0;  mem_we_reg <= 1'b0;  mem_addr_reg <= '0;  mem_wdata_reg <= '0;
      halted_reg <= 1'b0;  illegal_reg <= 1'b0;  misaligned_reg <= 1'b0;  retired_reg <= '0;
    end else begin
      state_reg <= state_next;  pc_reg <= pc_next;  ir_reg <= ir_next;
      a_reg <= a_next;  b_reg <= b_next;  alu_out_reg <= alu_out_next;  mdr_reg <= mdr_next;
      mem_req_reg <= mem_req_next;  mem_we_reg <= mem_we_next;
      mem_addr_reg <= mem_addr_next;  mem_wdata_reg <= mem_wdata_next;
      halted_reg <= halted_next;  illegal_reg <= illegal_next;
      misaligned_reg <= misaligned_next;  retired_reg <= retired_next;
    end
  end

  assign mem_req       = mem_req_reg;
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign halted        = halted_reg;
  assign illegal_instr = illegal_reg;
  assign misaligned    = misaligned_reg;
  assign retired_cnt   = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Scoreboard bench: expected bus transactions and retire latencies are queued
// per program; monitors pop and compare as the core presents them.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ack = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'hDEAD_BEEF;
  logic        halted, illegal_instr, misaligned;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  mips_multicycle_core #(.RESET_PC(32'h0), .CNT_WIDTH(32), .ENABLE_JUMP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .halted(halted),
    .illegal_instr(illegal_instr), .misaligned(misaligned), .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic [31:0] mem [0:255];
  txn_t        exp_q[$];
  int          lat_q[$];
  int          total = 0;
  int          bad = 0;
  int          ack_delay = 1;
  logic        stray_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ack after ack_delay request cycles; stray ack only while idle
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack = 1'b0;  wait_cnt = 0;
    end else if (!mem_req) begin
      mem_ack = stray_ack;  wait_cnt = 0;  mem_rdata = 32'hDEAD_BEEF;
    end else begin
      if (mem_ack) wait_cnt = 0;
      wait_cnt++;
      mem_ack = (wait_cnt >= ack_delay);
      mem_rdata = (mem_ack && !mem_we) ? mem[mem_addr[9:2]] : 32'hDEAD_BEEF;
    end
  end

  // Transaction monitor: hold-stability while waiting, scoreboard compare on ack
  logic pend = 1'b0;
  txn_t held, got_e;
  always @(negedge clk) begin
    #1;
    if (!rst_n || !mem_req) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("hold_addr", mem_addr, held.addr);
        check("hold_we", 32'(mem_we), 32'(held.we));
        if (held.we) check("hold_wdata", mem_wdata, held.wdata);
      end
      if (mem_ack) begin
        if (exp_q.size() == 0) begin
          total++;  bad++;
          $display("FAIL unexpected_txn: got we=%0d addr=%h expected none", mem_we, mem_addr);
        end else begin
          got_e = exp_q.pop_front();
          $display("txn we=%0d addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
          check("txn_we", 32'(mem_we), 32'(got_e.we));
          check("txn_addr", mem_addr, got_e.addr);
          if (got_e.we) check("txn_wdata", mem_wdata, got_e.wdata);
        end
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        pend = 1'b0;
      end else begin
        pend = 1'b1;
        held = '{mem_we, mem_addr, mem_wdata};
      end
    end
    if (rst_n && halted) check("req_after_halt", 32'(mem_req), 32'd0);
  end

  // Retire-latency monitor: cycles between successive retired_cnt increments
  int          lat_cyc = 0;
  int          lat_exp;
  logic [31:0] last_ret = '0;
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      lat_cyc = 0;  last_ret = '0;
    end else begin
      lat_cyc++;
      if (retired_cnt != last_ret) begin
        if (lat_q.size() == 0) begin
          total++;  bad++;
          $display("FAIL unexpected_retire: got count %0d expected no retire", retired_cnt);
        end else begin
          lat_exp = lat_q.pop_front();
          if (lat_exp != 0) check("retire_latency", 32'(lat_cyc), 32'(lat_exp));
        end
        lat_cyc = 0;  last_ret = retired_cnt;
      end
    end
  end

  task automatic push_r(input logic [31:0] a);
    exp_q.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b1, a, d});
  endtask

  task automatic push_lats(input int n, input int l);
    for (int i = 0; i < n; i++) lat_q.push_back(l);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  endtask

  task automatic hold_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();  lat_q.delete();
  endtask

  // Runs until halted (bounded); optionally patches word 0x100 once retired_cnt hits patch_cnt
  task automatic run_until_halt(input int budget, input int patch_cnt, input logic [31:0] patch_word);
    bit done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #2;
      if (patch_cnt >= 0 && retired_cnt == 32'(patch_cnt)) mem[64] = patch_word;
      if (halted) done = 1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL halt_timeout: got halted=0 expected halted=1 within %0d cycles", budget);
    end
  endtask

  task automatic end_run(input logic [31:0] exp_ret, input logic exp_ill, input logic exp_mis);
    repeat (6) @(posedge clk);
    #2;
    check("halted", 32'(halted), 32'd1);
    check("retired_cnt", retired_cnt, exp_ret);
    check("illegal_instr", 32'(illegal_instr), 32'(exp_ill));
    check("misaligned", 32'(misaligned), 32'(exp_mis));
    check("txn_left", 32'(exp_q.size()), 32'd0);
    check("retire_left", 32'(lat_q.size()), 32'd0);
  endtask

  task automatic load_basic();
    mem[0] = 32'h2001_0005;  // addi $1,$0,5
    mem[1] = 32'h2002_FFFD;  // addi $2,$0,-3
    mem[2] = 32'h0022_1820;  // add  $3,$1,$2
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // ---- Run 1: reset values, reset mid-fetch, stray ack, then basic program
    clear_mem();
    load_basic();
    mem[3] = 32'hFC00_0000;
    ack_delay = 50;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_illegal", 32'(illegal_instr), 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);
    check("rst_retired", retired_cnt, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10 && !mem_req; c++) begin
      @(posedge clk);
      #2;
    end
    check("req_rise", 32'(mem_req), 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_drop_req", 32'(mem_req), 32'd0);
    check("async_addr", mem_addr, 32'd0);
    stray_ack = 1'b1;
    exp_q.delete();  lat_q.delete();
    push_r(32'h0);  push_r(32'h4);  push_r(32'h8);  push_r(32'hC);
    lat_q.push_back(0);  lat_q.push_back(4);  lat_q.push_back(4);  lat_q.push_back(2);
    repeat (2) @(posedge clk);
    #2;
    ack_delay = 1;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check("post_rst_retired", retired_cnt, 32'd0);
    check("post_rst_halted", 32'(halted), 32'd0);
    @(posedge clk);
    #2 stray_ack = 1'b0;
    run_until_halt(200, -1, 32'h0);
    end_run(32'd4, 1'b0, 1'b0);

    // ---- Run 2: slow memory, sw/lw round trip, ALU ops, j, beq loop, $0 write
    hold_reset();
    clear_mem();
    load_basic();
    mem[3]  = 32'hAC03_0040;  // sw  $3,0x40($0)
    mem[4]  = 32'h8C04_0040;  // lw  $4,0x40($0)
    mem[5]  = 32'hAC04_0044;  // sw  $4,0x44($0)
    mem[6]  = 32'h0022_2822;  // sub $5,$1,$2
    mem[7]  = 32'h0041_302A;  // slt $6,$2,$1
    mem[8]  = 32'h0022_3824;  // and $7,$1,$2
    mem[9]  = 32'h0022_4025;  // or  $8,$1,$2
    mem[10] = 32'hAC05_0048;  // sw  $5,0x48
    mem[11] = 32'hAC06_004C;  // sw  $6,0x4C
    mem[12] = 32'hAC07_0050;  // sw  $7,0x50
    mem[13] = 32'hAC08_0054;  // sw  $8,0x54
    mem[14] = 32'h0800_0040;  // j   0x100
    mem[64] = 32'h1021_FFFF;  // beq $1,$1,-1 (self loop)
    mem[65] = 32'h2000_0007;  // addi $0,$0,7
    mem[66] = 32'hAC00_0058;  // sw  $0,0x58
    mem[67] = 32'hFC00_0000;  // halt
    push_r(32'h00);  push_r(32'h04);  push_r(32'h08);  push_r(32'h0C);
    push_w(32'h40, 32'd2);  push_r(32'h10);  push_r(32'h40);
    push_r(32'h14);  push_w(32'h44, 32'd2);
    push_r(32'h18);  push_r(32'h1C);  push_r(32'h20);  push_r(32'h24);
    push_r(32'h28);  push_w(32'h48, 32'd8);
    push_r(32'h2C);  push_w(32'h4C, 32'd1);
    push_r(32'h30);  push_w(32'h50, 32'd5);
    push_r(32'h34);  push_w(32'h54, 32'hFFFF_FFFD);
    push_r(32'h38);  push_r(32'h100);  push_r(32'h100);  push_r(32'h100);
    push_r(32'h104); push_r(32'h108);  push_w(32'h58, 32'd0);  push_r(32'h10C);
    lat_q.push_back(0);  push_lats(2, 6);  lat_q.push_back(8);  lat_q.push_back(9);
    lat_q.push_back(8);  push_lats(4, 6);  push_lats(4, 8);  lat_q.push_back(4);
    push_lats(3, 4);  lat_q.push_back(6);  lat_q.push_back(8);  lat_q.push_back(4);
    ack_delay = 3;
    rst_n = 1'b1;
    run_until_halt(1000, 17, 32'h1022_0004);  // beq $1,$2,+4 (not taken)
    end_run(32'd21, 1'b0, 1'b0);

    // ---- Run 3: unsupported funct (xor) is illegal and not retired
    hold_reset();
    clear_mem();
    mem[0] = 32'h0022_1826;
    push_r(32'h0);
    ack_delay = 1;
    rst_n = 1'b1;
    run_until_halt(100, -1, 32'h0);
    repeat (10) @(posedge clk);
    end_run(32'd0, 1'b1, 1'b0);

    // ---- Run 4: lw to a misaligned address halts without a data request
    hold_reset();
    clear_mem();
    mem[0] = 32'h8C05_0002;  // lw $5,2($0)
    push_r(32'h0);
    rst_n = 1'b1;
    run_until_halt(100, -1, 32'h0);
    end_run(32'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
